memory_bus: RTL and testbench
=============================

MEMORY_BUS -- requirements
Module: memory_bus

Interface
REQ-001 SHALL have parameter WIDTH, default word_size, data width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default mem_size, number of words (need not be a power of two).
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles (legal 1 or 2).
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, zero-fill the array after reset when 1.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-009 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  AW = $clog2(DEPTH)  word address.
REQ-011 SHALL have port req_wdata  input  WIDTH  write data.
REQ-012 SHALL have port req_be  input  WIDTH/8  byte write enables, bit i covers byte i.
REQ-013 SHALL have port rsp_valid  output  1  read-data strobe, one-cycle pulse per read.
REQ-014 SHALL have port rsp_rdata  output  WIDTH  read data, valid only while rsp_valid.
REQ-015 SHALL have port rsp_err  output  1  address >= DEPTH on the response being returned.
REQ-016 SHALL have port busy  output  1  clear sequence in progress.

Function
REQ-017 SHALL implement FSM states CLEAR and RUN; the reset state is CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-018 In CLEAR: write 0 to address cnt, one word per cycle, cnt counting 0..DEPTH-1; move to RUN on the cycle after the DEPTH-1 write; busy=1, req_ready=0.
REQ-019 In RUN: req_ready=1 every cycle, busy=0; no back-pressure on responses.
REQ-020 Accepted write SHALL update only bytes whose req_be bit is 1, visible to any read accepted on a later cycle.
REQ-021 Accepted read SHALL raise rsp_valid exactly RD_LAT cycles after acceptance, with rsp_rdata = word at req_addr.
REQ-022 Back-to-back reads SHALL be accepted every cycle and return in order, one response per cycle.
REQ-023 Writes SHALL produce no response.
REQ-024 Write with req_addr >= DEPTH SHALL be discarded with no state change; read with req_addr >= DEPTH SHALL return rsp_rdata=0 with rsp_err=1.
REQ-025 Write followed next cycle by a read of the same address SHALL return the new data.
REQ-026 rsp_rdata SHALL be 0 whenever rsp_valid=0.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and flush the read pipeline.
REQ-028 During reset, busy SHALL be 1 if CLEAR_ON_RESET=1, else 0.
REQ-029 Array contents SHALL NOT be reset directly; they are only cleared by the CLEAR sequence.
REQ-030 Reset during CLEAR SHALL restart the clear from address 0.
REQ-031 Reads in flight at reset SHALL be dropped and no response returned.

Structure
REQ-032 word, word_size and mem_size SHALL come from project_pkg; the FSM state enum SHALL be added to project_pkg.
REQ-033 The storage array with byte-enabled write port SHALL be a sub-module, memory_array, instantiated once.

Verification
REQ-034 Bench SHALL use WIDTH=16, DEPTH=12, RD_LAT=2, CLEAR_ON_RESET=1.
REQ-035 Reset release -> busy=1 for 12 cycles, then req_ready=1; reads of addresses 0..11 return 0x0000.
REQ-036 Write addr 3 = 0xABCD with be=11, then write addr 3 = 0x0012 with be=01 -> read addr 3 returns 0xAB12, rsp_valid exactly 2 cycles after acceptance.
REQ-037 Reads of addresses 0..11 on consecutive cycles -> 12 consecutive rsp_valid pulses, in order, with no gaps.
REQ-038 Write addr 13 = 0xFFFF, then read addr 13 -> rsp_rdata=0, rsp_err=1; read addr 11 still returns its prior value.
REQ-039 rst_n low at clear count 5 -> clear restarts at 0 and busy lasts a full 12 cycles; rst_n low with 2 reads in flight -> no rsp_valid after release.

Source files
------------

// File: rtl/project_pkg.sv
// -----------------------------------------------------------------------------
// project_pkg
// Shared project types and constants.
//   word_size / mem_size : default data width (bits) and depth (words)
//   word                 : one data word of word_size bits
//   bus_state_e          : memory_bus controller states (CLEAR, RUN)
//   addr_width()         : word-address width for a given depth (min 1 bit)
// -----------------------------------------------------------------------------
package project_pkg;

    localparam int word_size = 32;
    localparam int mem_size  = 64;

    typedef logic [word_size-1:0] word;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } bus_state_e;

    // A single-word memory still needs a one-bit address port.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/memory_array.sv
// -----------------------------------------------------------------------------
// memory_array
// DEPTH x WIDTH storage with one byte-enabled synchronous write port and one
// combinational read port. The storage is never reset.
//   clk    : write clock (rising edge)
//   we     : write strobe
//   waddr  : write word address (out-of-range writes are ignored)
//   wdata  : write data
//   wbe    : byte enables, bit i covers wdata[8*i +: 8]
//   raddr  : read word address
//   rdata  : word at raddr, zero when raddr is out of range
// -----------------------------------------------------------------------------
module memory_array
    import project_pkg::*;
#(
    parameter int WIDTH = word_size,
    parameter int DEPTH = mem_size,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic [AW-1:0]      raddr,
    output logic [WIDTH-1:0]   rdata
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];

    // Byte-granular write; bytes with a clear enable keep their old value.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Asynchronous read so the caller can register the data at acceptance.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) begin
            rdata = mem[raddr];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/memory_bus.sv
// -----------------------------------------------------------------------------
// memory_bus
// Valid/ready request port in front of a byte-enabled word memory. After reset
// the array is optionally zero-filled (CLEAR state, busy=1); afterwards every
// request is accepted. Reads return one response RD_LAT cycles after
// acceptance; writes are silent. Out-of-range writes are dropped, out-of-range
// reads return zero data with rsp_err set.
//   clk, rst_n            : clock, async active-low reset
//   req_valid / req_ready : request handshake
//   req_we                : 1 = write, 0 = read
//   req_addr              : word address
//   req_wdata / req_be    : write data and byte enables
//   rsp_valid             : one-cycle read response strobe
//   rsp_rdata / rsp_err   : read data (0 when idle) / address-range error
//   busy                  : clear sequence in progress
// -----------------------------------------------------------------------------
module memory_bus
    import project_pkg::*;
#(
    parameter int WIDTH          = word_size,
    parameter int DEPTH          = mem_size,
    parameter int RD_LAT         = 1,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int AW            = addr_width(DEPTH),
    localparam int NB            = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [NB-1:0]    req_be,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             busy
);

    localparam bus_state_e  RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    bus_state_e       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    // Read pipeline: stage 1 only used when RD_LAT == 2.
    logic             s1_valid_q, s1_valid_d;
    logic             s1_err_q, s1_err_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             accept_s;
    logic             rd_accept_s;
    logic             in_range_s;
    logic             mem_we_s;
    logic [AW-1:0]    mem_waddr_s;
    logic [WIDTH-1:0] mem_wdata_s;
    logic [NB-1:0]    mem_wbe_s;
    logic [WIDTH-1:0] mem_rdata_s;

    assign accept_s    = req_valid && ready_q;
    assign rd_accept_s = accept_s && !req_we;
    assign in_range_s  = (int'(req_addr) < DEPTH);

    memory_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (mem_waddr_s),
        .wdata (mem_wdata_s),
        .wbe   (mem_wbe_s),
        .raddr (req_addr),
        .rdata (mem_rdata_s)
    );

    // Controller: clear walk in CLEAR, bus writes routed to the array in RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = req_addr;
        mem_wdata_s = req_wdata;
        mem_wbe_s   = req_be;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_q;
                mem_wdata_s = '0;
                mem_wbe_s   = '1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + AW'(1);
                end
            end
            ST_RUN: begin
                mem_we_s = accept_s && req_we && in_range_s;
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
        endcase
        // Handshake outputs are registered, so they follow the next state.
        ready_d = (state_d == ST_RUN);
        busy_d  = (state_d == ST_CLEAR);
    end

    // Read response pipeline; data is captured at acceptance.
    always_comb begin
        s1_valid_d = rd_accept_s;
        s1_err_d   = rd_accept_s && !in_range_s;
        s1_data_d  = (rd_accept_s && in_range_s) ? mem_rdata_s : '0;
        if (RD_LAT == 2) begin
            rsp_valid_d = s1_valid_q;
            rsp_err_d   = s1_err_q;
            rsp_data_d  = s1_data_q;
        end else begin
            rsp_valid_d = s1_valid_d;
            rsp_err_d   = s1_err_d;
            rsp_data_d  = s1_data_d;
        end
    end

    // State and pipeline registers; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            busy_q      <= CLEAR_ON_RESET;
            s1_valid_q  <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            s1_valid_q  <= s1_valid_d;
            s1_err_q    <= s1_err_d;
            s1_data_q   <= s1_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_data_q;

endmodule

// File: tb/tb_memory_bus.sv
// -----------------------------------------------------------------------------
// tb_memory_bus
// Directed and random stimulus for memory_bus (WIDTH=16, DEPTH=12, RD_LAT=2,
// CLEAR_ON_RESET=1). A behavioural model (word array plus a queue of expected
// responses tagged with their due cycle) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_memory_bus;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 12;
    localparam int RD_LAT = 2;
    localparam int AW     = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic [1:0]       req_be;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    logic             busy;

    always #5 clk = ~clk;

    memory_bus #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .RD_LAT         (RD_LAT),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
        logic        err;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          clear_left = 0;
    logic [15:0] model_mem [DEPTH];
    rsp_t        exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check outputs mid-cycle, update model at the edge.
    task automatic do_cycle(input logic v, input logic we, input logic [3:0] addr,
                            input logic [15:0] d, input logic [1:0] be);
        rsp_t r;
        int   a;
        logic exp_ready;
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = d;
        req_be    = be;
        @(negedge clk);
        exp_ready = (clear_left == 0);
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        chk("busy", {31'd0, busy}, {31'd0, !exp_ready});
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, r.data});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
        end else begin
            chk("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
            chk("rsp_rdata_idle", {16'd0, rsp_rdata}, 32'd0);
            chk("rsp_err_idle", {31'd0, rsp_err}, 32'd0);
        end
        a = int'(addr);
        if (v && exp_ready) begin
            if (we) begin
                if (a < DEPTH) begin
                    if (be[0]) model_mem[a][7:0]  = d[7:0];
                    if (be[1]) model_mem[a][15:8] = d[15:8];
                end
            end else begin
                r.due  = cyc + RD_LAT;
                r.data = (a < DEPTH) ? model_mem[a] : 16'h0000;
                r.err  = (a >= DEPTH);
                exp_q.push_back(r);
            end
        end
        if (clear_left > 0) clear_left--;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Assert reset mid-cycle, check outputs collapse at once, then release.
    task automatic apply_reset();
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    endtask

    // Count busy cycles after release until the bus becomes ready.
    task automatic measure_clear();
        int   n = 0;
        bit   done = 1'b0;
        logic rdy = 1'b0;
        req_valid = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                n++;
            end else begin
                done = 1'b1;
                rdy  = req_ready;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        clear_left = 0;
        chk("clear_busy_cycles", n, DEPTH);
        chk("ready_after_clear", {31'd0, rdy}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        @(posedge clk);
        #1;

        // Reset, clear sequence, then every word reads back zero in order.
        apply_reset();
        measure_clear();
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 4'(i), 16'h0000, 2'b00);
        repeat (3) do_cycle(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);

        // Byte-enable merge and exact read latency.
        do_cycle(1'b1, 1'b1, 4'd3, 16'hABCD, 2'b11);
        do_cycle(1'b1, 1'b1, 4'd3, 16'h0012, 2'b01);
        do_cycle(1'b1, 1'b0, 4'd3, 16'h0000, 2'b00);
        do_cycle(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);
        chk("be_merge_valid", {31'd0, rsp_valid}, 32'd1);
        chk("be_merge_data", {16'd0, rsp_rdata}, 32'h0000AB12);
        repeat (2) do_cycle(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);

        // Out-of-range write discarded; out-of-range read flags error.
        do_cycle(1'b1, 1'b1, 4'd11, 16'h5A5A, 2'b11);
        do_cycle(1'b1, 1'b1, 4'd13, 16'hFFFF, 2'b11);
        do_cycle(1'b1, 1'b0, 4'd13, 16'h0000, 2'b00);
        do_cycle(1'b1, 1'b0, 4'd11, 16'h0000, 2'b00);
        repeat (3) do_cycle(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);

        // Random traffic including out-of-range addresses and partial writes.
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 16'($urandom),
                     2'($urandom_range(0, 3)));
        end
        repeat (3) do_cycle(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);

        // Reset at clear count 5 restarts the full clear.
        apply_reset();
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 4'(i), 16'h0000, 2'b00);
        apply_reset();
        measure_clear();

        // Reset with reads in flight: no response may follow release.
        do_cycle(1'b1, 1'b1, 4'd2, 16'h1234, 2'b11);
        do_cycle(1'b1, 1'b0, 4'd2, 16'h0000, 2'b00);
        do_cycle(1'b1, 1'b0, 4'd5, 16'h0000, 2'b00);
        apply_reset();
        for (int i = 0; i < DEPTH + 4; i++) do_cycle(1'b1, 1'b0, 4'd2, 16'h0000, 2'b00);
        repeat (3) do_cycle(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
